// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: 2-flop rx sync, baud prescaler, oversample and bit
// counters, 8N1 frame recovery, byte delivery over a valid/ready handshake.
// Ports: clock, reset (async high), rx, rx_ready in;
//        rx_data, rx_valid, busy, framing_error, overrun_error out.
module uart_rx_sequencer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int BAUD_DIV   = 27
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 framing_error,
  output logic                 overrun_error
);

  localparam int PW = $clog2(BAUD_DIV + 1);
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(BAUD_DIV - 1);
  localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_MID   = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } state_t;

  state_t               state;
  logic                 rx_m;
  logic                 rx_s;
  logic [PW-1:0]        pre_cnt;
  logic [OW-1:0]        os_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 tick;

  // Idle-high line: sync flops reset to 1 so reset never looks like a start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign tick = (state != IDLE) && (pre_cnt == PRE_LAST);
  assign busy = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pre_cnt       <= '0;
      os_cnt        <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun_error <= 1'b0;

      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;

      if (state == IDLE || tick)
        pre_cnt <= '0;
      else
        pre_cnt <= pre_cnt + 1'b1;

      if (tick)
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;

      unique case (state)
        IDLE: begin
          os_cnt <= '0;
          if (!rx_s)
            state <= START;
        end
        START: begin
          if (tick && os_cnt == OS_MID) begin
            os_cnt  <= '0;
            bit_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (tick && os_cnt == OS_LAST) begin
            shift[bit_cnt] <= rx_s;
            if (bit_cnt == BIT_LAST)
              state <= STOP;
            else
              bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick && os_cnt == OS_LAST) begin
            if (rx_s) begin
              // A same-cycle accept frees the slot for the new byte.
              if (!rx_valid || rx_ready) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                overrun_error <= 1'b1;
              end
              state <= IDLE;
            end else begin
              framing_error <= 1'b1;
              state         <= WAIT_HI;
            end
          end
        end
        WAIT_HI: begin
          if (rx_s) begin
            os_cnt <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer at BAUD_DIV=4, OVERSAMPLE=16 (64 clk/bit).
// One task per scenario, inline checks, one summary line.
module tb_uart_rx_sequencer;

  localparam int BIT_CLKS = 64;

  logic       clock;
  logic       reset;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       framing_error;
  logic       overrun_error;

  int n_cmp;
  int n_bad;
  int fe_cnt;
  int ov_cnt;
  logic [7:0] acc_q[$];

  uart_rx_sequencer #(
    .DATA_BITS (8),
    .OVERSAMPLE(16),
    .BAUD_DIV  (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .busy         (busy),
    .framing_error(framing_error),
    .overrun_error(overrun_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Handshakes and error pulses seen mid-cycle; inputs change at posedge+1.
  always @(negedge clock) begin
    if (!reset) begin
      if (rx_valid && rx_ready) acc_q.push_back(rx_data);
      if (framing_error) fe_cnt++;
      if (overrun_error) ov_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_mon();
    acc_q.delete();
    fe_cnt = 0;
    ov_cnt = 0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    step(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      step(BIT_CLKS);
    end
    rx = stop;
    step(BIT_CLKS);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b0;
    step(3);
    @(negedge clock);
    n_cmp++;
    if ({rx_valid, busy, framing_error, overrun_error, rx_data} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_outputs got=%h want=000",
               {rx_valid, busy, framing_error, overrun_error, rx_data});
    end
    step(1);
    reset = 1'b0;
    step(4);
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_busy got=%b want=0", busy);
    end
  endtask

  task automatic test_single();
    clear_mon();
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    step(BIT_CLKS);
    @(negedge clock);
    n_cmp++;
    if (acc_q.size() !== 1) begin
      n_bad++;
      $display("FAIL single_count got=%0d want=1", acc_q.size());
    end else begin
      n_cmp++;
      if (acc_q[0] !== 8'hA5) begin
        n_bad++;
        $display("FAIL single_data got=%h want=a5", acc_q[0]);
      end
    end
    n_cmp++;
    if (fe_cnt !== 0 || ov_cnt !== 0) begin
      n_bad++;
      $display("FAIL single_errs got fe=%0d ov=%0d want 0/0", fe_cnt, ov_cnt);
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx = 1'b0;
    step(10);
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL glitch_start got busy=%b want=1", busy);
    end
    step(10);
    rx = 1'b1;
    step(60);
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || rx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_reject got busy=%b valid=%b want 0/0",
               busy, rx_valid);
    end
    n_cmp++;
    if (acc_q.size() !== 0 || fe_cnt !== 0) begin
      n_bad++;
      $display("FAIL glitch_flags got n=%0d fe=%0d want 0/0",
               acc_q.size(), fe_cnt);
    end
  endtask

  task automatic test_framing();
    clear_mon();
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    step(200);
    @(negedge clock);
    n_cmp++;
    if (fe_cnt !== 1) begin
      n_bad++;
      $display("FAIL framing_pulse got=%0d want=1", fe_cnt);
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL break_busy got=%b want=1", busy);
    end
    n_cmp++;
    if (acc_q.size() !== 0 || rx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL framing_nodeliver got n=%0d valid=%b want 0/0",
               acc_q.size(), rx_valid);
    end
    rx = 1'b1;
    step(5);
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL break_release got busy=%b want=0", busy);
    end
  endtask

  task automatic test_overrun();
    clear_mon();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    step(BIT_CLKS);
    @(negedge clock);
    n_cmp++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      n_bad++;
      $display("FAIL overrun_hold got valid=%b data=%h want 1/11",
               rx_valid, rx_data);
    end
    n_cmp++;
    if (ov_cnt !== 1) begin
      n_bad++;
      $display("FAIL overrun_pulse got=%0d want=1", ov_cnt);
    end
    rx_ready = 1'b1;
    step(2);
    @(negedge clock);
    n_cmp++;
    if (rx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_clear got valid=%b want=0", rx_valid);
    end
    n_cmp++;
    if (acc_q.size() !== 1 || acc_q[0] !== 8'h11) begin
      n_bad++;
      $display("FAIL overrun_accept got n=%0d want one byte 11", acc_q.size());
    end
  endtask

  task automatic test_midframe_reset();
    clear_mon();
    rx_ready = 1'b1;
    rx = 1'b0;
    step(BIT_CLKS);
    rx = 1'b1;
    step(BIT_CLKS * 4 + BIT_CLKS / 2);
    reset = 1'b1;
    step(1);
    @(negedge clock);
    n_cmp++;
    if ({rx_valid, busy, framing_error, overrun_error, rx_data} !== 12'h000) begin
      n_bad++;
      $display("FAIL midreset_outputs got=%h want=000",
               {rx_valid, busy, framing_error, overrun_error, rx_data});
    end
    step(2);
    reset = 1'b0;
    step(BIT_CLKS);
    send_frame(8'h5A, 1'b1);
    step(BIT_CLKS);
    @(negedge clock);
    n_cmp++;
    if (acc_q.size() !== 1 || acc_q[0] !== 8'h5A) begin
      n_bad++;
      $display("FAIL midreset_next got n=%0d want one byte 5a", acc_q.size());
    end
    n_cmp++;
    if (fe_cnt !== 0 || ov_cnt !== 0) begin
      n_bad++;
      $display("FAIL midreset_errs got fe=%0d ov=%0d want 0/0", fe_cnt, ov_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    exp[0] = 8'h00;
    exp[1] = 8'hFF;
    exp[2] = 8'h81;
    clear_mon();
    rx_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      send_frame(exp[i], 1'b1);
    step(BIT_CLKS);
    @(negedge clock);
    n_cmp++;
    if (acc_q.size() !== 3) begin
      n_bad++;
      $display("FAIL b2b_count got=%0d want=3", acc_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (acc_q[i] !== exp[i]) begin
          n_bad++;
          $display("FAIL b2b_data%0d got=%h want=%h", i, acc_q[i], exp[i]);
        end
      end
    end
    n_cmp++;
    if (fe_cnt !== 0 || ov_cnt !== 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_state got fe=%0d ov=%0d busy=%b want 0/0/0",
               fe_cnt, ov_cnt, busy);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    fe_cnt = 0;
    ov_cnt = 0;
    test_reset();
    test_single();
    test_glitch();
    test_framing();
    test_overrun();
    test_midframe_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
